// File: rtl/input_loader.sv
// Packs a serial element stream into COL-wide vectors and streams them to the systolic core on start.
// Optional INPUT_LOADER_REPLAY_EN keeps the buffered vectors after a run so a later start replays them.
module input_loader #(
   parameter int DEP   = 8,
   parameter int COL   = 2,
   parameter int VECS  = 4,
   parameter int FLUSH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DEP-1:0]             s_data,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic                       start,
   output logic [DEP-1:0]             data_out [0:COL-1],
   output logic                       core_rst,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(VECS+1)-1:0]  count
);

   // state    | meaning
   // S_LOAD   | accepting elements, core held in reset
   // S_PRIME  | one cycle of core reset before data arrives
   // S_STREAM | one buffered vector per cycle onto data_out
   // S_FLUSH  | zeros on data_out while the core pipeline drains

   localparam int CW = $clog2(VECS + 1);
   localparam int PW = (VECS > 1) ? $clog2(VECS) : 1;
   localparam int IW = (COL > 1) ? $clog2(COL) : 1;
   localparam int FW = (FLUSH > 1) ? $clog2(FLUSH) : 1;

   localparam logic [CW-1:0] VECS_C    = CW'(VECS);
   localparam logic [IW-1:0] LAST_COL  = IW'(COL - 1);
   localparam logic [FW-1:0] FLUSH_TOP = FW'(FLUSH - 1);

   typedef enum logic [1:0] {
      S_LOAD,
      S_PRIME,
      S_STREAM,
      S_FLUSH
   } state_t;

   state_t         state;
   logic [DEP-1:0] vbuf [0:VECS-1][0:COL-1];
   logic [IW-1:0]  col_idx;
   logic [PW-1:0]  wr_ptr;
   logic [CW-1:0]  rd_ptr;
   logic [FW-1:0]  flush_cnt;
   logic           replay_pend;

   logic           start_ok;
   logic           accept;
   logic           last_col;
   logic           stream_end;
   logic           finish;
   logic [CW-1:0]  count_base;

   always_comb begin
      start_ok   = start && (state == S_LOAD) && (count != '0) && (col_idx == '0);
      s_ready    = !rst && (state == S_LOAD) && ((count < VECS_C) || replay_pend) && !start_ok;
      accept     = s_valid && s_ready;
      last_col   = (col_idx == LAST_COL);
      stream_end = (state == S_STREAM) && (rd_ptr == count);
      // With no drain cycles the run completes straight out of STREAM.
      finish     = ((state == S_FLUSH) && (flush_cnt == '0)) ||
                   ((FLUSH == 0) && stream_end);
      count_base = replay_pend ? '0 : count;
   end

`ifdef INPUT_LOADER_REPLAY_EN
   always_ff @(posedge clk) begin
      if (rst)
         replay_pend <= 1'b0;
      else if (finish)
         replay_pend <= 1'b1;
      else if (accept)
         replay_pend <= 1'b0;
   end
`else
   assign replay_pend = 1'b0;
`endif

   // The partially filled slot is outside count, so elements can be written in place.
   always_ff @(posedge clk) begin
      if (accept)
         vbuf[wr_ptr][col_idx] <= s_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_LOAD;
         count     <= '0;
         col_idx   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         flush_cnt <= '0;
         core_rst  <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         for (int i = 0; i < COL; i++)
            data_out[i] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_LOAD: begin
               if (start_ok) begin
                  state  <= S_PRIME;
                  busy   <= 1'b1;
                  rd_ptr <= '0;
               end else if (accept) begin
                  if (last_col) begin
                     col_idx <= '0;
                     count   <= count_base + CW'(1);
                     wr_ptr  <= wr_ptr + PW'(1);
                  end else begin
                     col_idx <= col_idx + IW'(1);
                     if (replay_pend)
                        count <= '0;
                  end
               end
            end
            S_PRIME: begin
               state    <= S_STREAM;
               core_rst <= 1'b0;
               data_out <= vbuf[0];
               rd_ptr   <= CW'(1);
            end
            S_STREAM: begin
               if (stream_end) begin
                  state     <= S_FLUSH;
                  flush_cnt <= FLUSH_TOP;
                  for (int i = 0; i < COL; i++)
                     data_out[i] <= '0;
               end else begin
                  data_out <= vbuf[rd_ptr[PW-1:0]];
                  rd_ptr   <= rd_ptr + CW'(1);
               end
            end
            S_FLUSH: begin
               flush_cnt <= flush_cnt - FW'(1);
            end
            default: state <= S_LOAD;
         endcase

         if (finish) begin
            state    <= S_LOAD;
            busy     <= 1'b0;
            done     <= 1'b1;
            core_rst <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            col_idx  <= '0;
            for (int i = 0; i < COL; i++)
               data_out[i] <= '0;
`ifndef INPUT_LOADER_REPLAY_EN
            count    <= '0;
`endif
         end
      end
   end

endmodule
